// File: rtl/interrupt_controller.sv
// Interrupt collector: latches peripheral request edges into IF, masks them with IE,
// raises cpu_int and, on dispatch, acks the highest-priority source and supplies its vector.
module interrupt_controller #(
    parameter int          NUM_SRC  = 5,
    parameter logic [15:0] IF_ADDR  = 16'hFF0F,
    parameter logic [15:0] IE_ADDR  = 16'hFFFF,
    parameter logic [7:0]  VEC_BASE = 8'h40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        a,
    output logic [7:0]         dout,
    input  logic [7:0]         din,
    input  logic               rd,
    input  logic               wr,
    input  logic [NUM_SRC-1:0] int_req,
    output logic [NUM_SRC-1:0] int_ack,
    output logic               cpu_int,
    input  logic               cpu_int_taken,
    output logic [7:0]         cpu_vector
);

    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t state_q, state_d;

    logic [NUM_SRC-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [NUM_SRC-1:0] req_q;
    logic [NUM_SRC-1:0] ack_q, ack_d;
    logic [7:0]         vec_q, vec_d;

    logic               if_wr, ie_wr;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] if_after_wr;
    logic [NUM_SRC-1:0] pend_after_wr;
    logic [NUM_SRC-1:0] clr_mask;
    logic [NUM_SRC-1:0] sel_onehot;
    logic [SEL_W-1:0]   sel_idx;
    logic               sel_valid;
    logic [7:0]         sel_vec;

    // dout does not depend on the read strobe
    logic unused_rd;
    assign unused_rd = rd;

    assign if_wr = wr && (a == IF_ADDR);
    assign ie_wr = wr && (a == IE_ADDR);
    assign rise  = int_req & ~req_q;

    // Dispatch arbitrates on IF/IE as already modified by a same-cycle bus write
    assign if_after_wr   = if_wr ? din[NUM_SRC-1:0] : if_q;
    assign ie_d          = ie_wr ? din : ie_q;
    assign pend_after_wr = if_after_wr & ie_d[NUM_SRC-1:0];

    always_comb begin : pick_lowest
        sel_onehot = '0;
        sel_idx    = '0;
        sel_valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (pend_after_wr[i] && !sel_valid) begin
                sel_valid     = 1'b1;
                sel_idx       = SEL_W'(i);
                sel_onehot[i] = 1'b1;
            end
        end
    end

    assign sel_vec = VEC_BASE + 8'({sel_idx, 3'b000});

    always_comb begin : fsm_next
        state_d  = state_q;
        ack_d    = '0;
        vec_d    = vec_q;
        clr_mask = '0;
        case (state_q)
            IDLE: begin
                if (cpu_int_taken) begin
                    state_d = ACK;
                    if (sel_valid) begin
                        ack_d    = sel_onehot;
                        vec_d    = sel_vec;
                        clr_mask = sel_onehot;
                    end else begin
                        vec_d = 8'h00;
                    end
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Rising edges are applied last so they survive a clearing write or dispatch
    assign if_d = (if_after_wr & ~clr_mask) | rise;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            if_q    <= '0;
            ie_q    <= '0;
            req_q   <= '0;
            ack_q   <= '0;
            vec_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            if_q    <= if_d;
            ie_q    <= ie_d;
            req_q   <= int_req;
            ack_q   <= ack_d;
            vec_q   <= vec_d;
        end
    end

    always_comb begin : bus_read
        if (a == IF_ADDR) begin
            dout = {{(8 - NUM_SRC){1'b1}}, if_q};
        end else if (a == IE_ADDR) begin
            dout = ie_q;
        end else begin
            dout = 8'hFF;
        end
    end

    assign cpu_int    = |(if_q & ie_q[NUM_SRC-1:0]);
    assign int_ack    = ack_q;
    assign cpu_vector = vec_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Bench for interrupt_controller: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of IF/IE, dispatch and acknowledge.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a = 16'h0000;
    logic [7:0]  dout;
    logic [7:0]  din = 8'h00;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  int_req = 5'b0;
    logic [4:0]  int_ack;
    logic        cpu_int;
    logic        cpu_int_taken = 1'b0;
    logic [7:0]  cpu_vector;

    int checks = 0;
    int failures = 0;

    // reference model state
    logic [4:0] m_if, m_prev, m_ack;
    logic [7:0] m_ie, m_vec;
    bit         m_inack;

    interrupt_controller #(
        .NUM_SRC (5),
        .IF_ADDR (16'hFF0F),
        .IE_ADDR (16'hFFFF),
        .VEC_BASE(8'h40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .dout         (dout),
        .din          (din),
        .rd           (rd),
        .wr           (wr),
        .int_req      (int_req),
        .int_ack      (int_ack),
        .cpu_int      (cpu_int),
        .cpu_int_taken(cpu_int_taken),
        .cpu_vector   (cpu_vector)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_if = '0; m_ie = '0; m_prev = '0; m_ack = '0; m_vec = 8'h00; m_inack = 0;
    endtask

    function automatic logic [7:0] model_read(input logic [15:0] addr);
        if (addr == 16'hFF0F) return {3'b111, m_if};
        if (addr == 16'hFFFF) return m_ie;
        return 8'hFF;
    endfunction

    // One clock cycle: drive inputs, check outputs at negedge, advance model at posedge.
    task automatic tick(input logic [15:0] addr, input logic [7:0] data, input logic w,
                        input logic [4:0] req, input logic take);
        logic [4:0] nif, nack, p;
        logic [7:0] nie, nvec;
        bit         ninack;
        a = addr; din = data; wr = w; int_req = req; cpu_int_taken = take;
        rd = ~w;
        @(negedge clk);
        check("dout", dout, model_read(addr));
        check("cpu_int", cpu_int, |(m_if & m_ie[4:0]));
        check("int_ack", int_ack, m_ack);
        check("cpu_vector", cpu_vector, m_vec);
        nif = m_if; nie = m_ie; nack = '0; nvec = m_vec; ninack = 0;
        if (w && addr == 16'hFF0F) nif = data[4:0];
        if (w && addr == 16'hFFFF) nie = data;
        if (!m_inack && take) begin
            ninack = 1;
            p = nif & nie[4:0];
            nvec = 8'h00;
            for (int k = 0; k < 5; k++) begin
                if (p[k]) begin
                    nif[k] = 1'b0;
                    nack   = 5'(1 << k);
                    nvec   = 8'(8'h40 + 8 * k);
                    break;
                end
            end
        end
        nif = nif | (req & ~m_prev);
        @(posedge clk);
        #1;
        m_if = nif; m_ie = nie; m_ack = nack; m_vec = nvec; m_inack = ninack; m_prev = req;
    endtask

    task automatic idle(input logic [15:0] addr, input logic [4:0] req);
        tick(addr, 8'h00, 1'b0, req, 1'b0);
    endtask

    initial begin
        logic [4:0]  req;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        w, take;
        int          r;

        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        idle(16'hFF0F, 5'b0);
        a = 16'hFF0F; #1 check("rst_if", dout, 8'hE0);
        a = 16'hFFFF; #1 check("rst_ie", dout, 8'h00);
        check("rst_cpu_int", cpu_int, 1'b0);
        check("rst_ack", int_ack, 5'b0);

        // timer interrupt
        tick(16'hFFFF, 8'h04, 1'b1, 5'b00000, 1'b0);
        idle(16'hFF0F, 5'b00100);
        a = 16'hFF0F; #1 check("timer_if", dout, 8'hE4);
        check("timer_cpu_int", cpu_int, 1'b1);
        tick(16'hFF0F, 8'h00, 1'b0, 5'b00100, 1'b1);
        check("timer_vec", cpu_vector, 8'h50);
        check("timer_ack", int_ack, 5'b00100);
        a = 16'hFF0F; #1 check("timer_if_clr", dout, 8'hE0);
        idle(16'hFF0F, 5'b00000);
        check("timer_ack_pulse", int_ack, 5'b0);

        // priority order
        tick(16'hFF0F, 8'h1F, 1'b1, 5'b0, 1'b0);
        tick(16'hFFFF, 8'h1F, 1'b1, 5'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick(16'hFF0F, 8'h00, 1'b0, 5'b0, 1'b1);
            check("prio_vec", cpu_vector, 32'(8'h40 + 8 * k));
            check("prio_ack", int_ack, 32'(1 << k));
            tick(16'hFF0F, 8'h00, 1'b0, 5'b0, 1'b1); // take in ACK is ignored
        end
        check("prio_cpu_int_done", cpu_int, 1'b0);

        // dispatch cancelled by same-cycle IF write
        tick(16'hFF0F, 8'h01, 1'b1, 5'b0, 1'b0);
        tick(16'hFFFF, 8'h01, 1'b1, 5'b0, 1'b0);
        tick(16'hFF0F, 8'h00, 1'b1, 5'b0, 1'b1);
        check("cancel_vec", cpu_vector, 8'h00);
        check("cancel_ack", int_ack, 5'b0);
        a = 16'hFF0F; #1 check("cancel_if", dout, 8'hE0);
        idle(16'hFF0F, 5'b0);

        // rising edge beats a clearing write; held level does not re-set
        tick(16'hFF0F, 8'h00, 1'b1, 5'b01000, 1'b0);
        a = 16'hFF0F; #1 check("edge_beats_clear", dout, 8'hE8);
        tick(16'hFF0F, 8'h00, 1'b1, 5'b01000, 1'b0);
        idle(16'hFF0F, 5'b01000);
        a = 16'hFF0F; #1 check("level_no_reset", dout, 8'hE0);
        idle(16'hFF0F, 5'b00000);

        // async reset during ACK
        tick(16'hFF0F, 8'h02, 1'b1, 5'b0, 1'b0);
        tick(16'hFFFF, 8'h02, 1'b1, 5'b0, 1'b0);
        tick(16'hFF0F, 8'h00, 1'b0, 5'b0, 1'b1);
        check("areset_pre_ack", int_ack, 5'b00010);
        wr = 1'b0; cpu_int_taken = 1'b0; int_req = 5'b0;
        rst = 1'b1;
        #1;
        check("areset_ack", int_ack, 5'b0);
        check("areset_vec", cpu_vector, 8'h00);
        a = 16'hFF0F; #1 check("areset_if", dout, 8'hE0);
        a = 16'hFFFF; #1 check("areset_ie", dout, 8'h00);
        model_reset();
        #1 rst = 1'b0;

        // randomized traffic
        req = 5'b0;
        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0, 1:    addr = 16'hFF0F;
                2:       addr = 16'hFFFF;
                default: addr = 16'($urandom);
            endcase
            data = 8'($urandom);
            w    = ($urandom % 4) == 0;
            req  = req ^ (5'($urandom) & 5'($urandom) & 5'($urandom));
            if (|(m_if & m_ie[4:0])) take = ($urandom % 3) == 0;
            else                     take = ($urandom % 10) == 0;
            tick(addr, data, w, req, take);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL timeout: simulation did not finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
